// File: rtl/answers_poller.sv
// answers_poller: initiator side of the answer-table interface.
// Sweeps addresses 0..N_WORDS-1 against a registered responder, captures each
// returned byte onto a valid/ready stream, checks the fixed data pattern and
// that the frame counter held in word 0 advances by one from frame to frame.
module answers_poller #(
  parameter int N_WORDS   = 18,
  parameter int DWELL     = 2,
  parameter int FRAME_GAP = 4,
  parameter int IDLE_ADDR = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr_err,
  output logic [4:0] addr_o,
  input  logic [7:0] data_i,
  output logic [7:0] out_data,
  output logic [4:0] out_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       err_pat,
  output logic       err_seq,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETUP, PUSH, GAP} state_t;

  localparam logic [4:0] LAST_IDX   = 5'(N_WORDS - 1);
  localparam logic [4:0] IDLE_A     = 5'(IDLE_ADDR);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LAST   = 8'(FRAME_GAP - 1);

  state_t     state, state_nxt;
  logic [4:0] idx;
  logic [7:0] dwell_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] pending;
  logic       first;

  logic sample_ev;
  logic hs;
  logic last_hs;
  logic gap_end;
  logic pat_bad;
  logic seq_bad;

  // Expected contents of word k (k >= 1): 10*k, wrapped to 8 bits.
  function automatic logic [7:0] pattern_of(input logic [4:0] k);
    logic [7:0] k8;
    k8 = {3'b000, k};
    return (k8 << 3) + (k8 << 1);
  endfunction

  // Sequence check: the new counter must be the previous one plus one, 255 -> 0 legal.
  function automatic logic seq_broken(input logic [7:0] prev, input logic [7:0] cur);
    return cur != (prev + 8'd1);
  endfunction

  assign sample_ev = (state == SETUP) && (dwell_cnt == DWELL_LAST);
  assign hs        = (state == PUSH) && out_valid && out_ready;
  assign last_hs   = hs && (idx == LAST_IDX);
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
  assign pat_bad   = sample_ev && (idx != 5'd0) && (data_i != pattern_of(idx));
  assign seq_bad   = last_hs && !first && seq_broken(frame_cnt, pending);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; run is only consulted in IDLE and at the end of the gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = SETUP;
      SETUP:   if (sample_ev) state_nxt = PUSH;
      PUSH:    if (hs) state_nxt = (idx == LAST_IDX) ? GAP : SETUP;
      GAP:     if (gap_end) state_nxt = run ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and busy follow the state; addr stays on idx through the whole push.
  always_comb begin
    addr_o = IDLE_A;
    busy   = 1'b1;
    case (state)
      IDLE:        begin addr_o = IDLE_A; busy = 1'b0; end
      SETUP, PUSH: addr_o = idx;
      default:     addr_o = IDLE_A;
    endcase
  end

  // Counters, capture register, frame bookkeeping and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 5'd0;
      dwell_cnt  <= 8'd0;
      gap_cnt    <= 8'd0;
      out_data   <= 8'd0;
      out_idx    <= 5'd0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
      pending    <= 8'd0;
      first      <= 1'b1;
      err_pat    <= 1'b0;
      err_seq    <= 1'b0;
    end else begin
      frame_done <= last_hs;
      dwell_cnt  <= (state == SETUP && !sample_ev) ? dwell_cnt + 8'd1 : 8'd0;
      gap_cnt    <= (state == GAP && !gap_end) ? gap_cnt + 8'd1 : 8'd0;

      if (sample_ev) begin
        out_data  <= data_i;
        out_idx   <= idx;
        out_valid <= 1'b1;
        if (idx == 5'd0) pending <= data_i;
      end

      if (hs) begin
        out_valid <= 1'b0;
        idx       <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
      end

      if (last_hs) begin
        frame_cnt <= pending;
        first     <= 1'b0;
      end

      // A fresh error on the same edge as clr_err keeps the flag set.
      err_pat <= (err_pat & ~clr_err) | pat_bad;
      err_seq <= (err_seq & ~clr_err) | seq_bad;
    end
  end

endmodule

// File: tb/tb_answers_poller.sv
// Testbench for answers_poller with a behavioural registered answer-table responder.
module tb_answers_poller;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       clr_err;
  logic [4:0] addr_o;
  logic [7:0] data_i;
  logic [7:0] out_data;
  logic [4:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       err_pat;
  logic       err_seq;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_fd;

  // Responder model controls.
  logic [7:0] resp_cnt;
  logic       resp_armed;
  logic       preset_en;
  logic [7:0] preset_val;
  logic       corrupt_arm;

  answers_poller dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .clr_err    (clr_err),
    .addr_o     (addr_o),
    .data_i     (data_i),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_pat    (err_pat),
    .err_seq    (err_seq),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered responder: word 0 = counter, word k = 10*k; reading word 17 after
  // word 0 advances the counter. Outside the table the output is held.
  always @(posedge clk) begin
    if (preset_en) begin
      resp_cnt   <= preset_val;
      resp_armed <= 1'b0;
    end else begin
      if (addr_o == 5'd0) resp_armed <= 1'b1;
      if (addr_o == 5'd17 && resp_armed) begin
        resp_cnt   <= resp_cnt + 8'd1;
        resp_armed <= 1'b0;
      end
    end
    if (addr_o == 5'd0)
      data_i <= resp_cnt;
    else if (addr_o < 5'd18)
      data_i <= (addr_o == 5'd5 && corrupt_arm) ? 8'd51 : 8'(addr_o * 10);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_frame_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", budget);
    end
  endtask

  task automatic wait_word(input logic [4:0] want, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL word_timeout: idx %0d not presented within %0d cycles", want, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    preset_en = 1'b1; preset_val = 8'd0; corrupt_arm = 1'b0;
    repeat (3) tick();
    checks++; if (addr_o !== 5'd31)  begin errors++; $display("FAIL reset_addr: got %0d want 31", addr_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", out_data); end
    checks++; if (out_idx !== 5'd0)  begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
    checks++; if ({err_pat, err_seq} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b%b want 00", err_pat, err_seq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0; preset_en = 1'b0;
    tick();
  endtask

  task automatic test_single_frame;
    int c0, fd, n;
    logic [4:0] got_idx [0:31];
    logic [7:0] got_data[0:31];
    logic [7:0] exp_d;
    c0 = cyc; fd = -1; n = 0;
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && n < 32) begin
        got_idx[n] = out_idx; got_data[n] = out_data; n++;
        checks++;
        if (addr_o !== out_idx) begin errors++; $display("FAIL push_addr: got %0d want %0d", addr_o, out_idx); end
      end
      if (frame_done) begin fd = cyc; break; end
    end
    checks++; if (n != 18) begin errors++; $display("FAIL word_count: got %0d want 18", n); end
    for (int k = 0; k < n && k < 18; k++) begin
      exp_d = 8'(k * 10);
      checks++;
      if (got_idx[k] !== 5'(k) || got_data[k] !== exp_d) begin
        errors++;
        $display("FAIL word_%0d: got idx %0d data %0d want idx %0d data %0d", k, got_idx[k], got_data[k], k, exp_d);
      end
    end
    checks++; if (fd - c0 != 55) begin errors++; $display("FAIL fd_latency: got %0d want 55", fd - c0); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL f1_cnt: got %0d want 0", frame_cnt); end
    checks++; if ({err_pat, err_seq} !== 2'b00) begin errors++; $display("FAIL f1_err: got %b%b want 00", err_pat, err_seq); end
    last_fd = fd;
  endtask

  task automatic test_back_to_back;
    int fd;
    for (int f = 1; f <= 2; f++) begin
      wait_frame_done(100, fd);
      checks++; if (frame_cnt !== 8'(f)) begin errors++; $display("FAIL b2b_cnt%0d: got %0d want %0d", f, frame_cnt, f); end
      checks++; if (fd - last_fd != 58) begin errors++; $display("FAIL b2b_period%0d: got %0d want 58", f, fd - last_fd); end
      last_fd = fd;
    end
    checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL b2b_seq: got %b want 0", err_seq); end
    run = 1'b0;
    wait_idle(20);
    checks++; if (addr_o !== 5'd31) begin errors++; $display("FAIL b2b_idle_addr: got %0d want 31", addr_o); end
  endtask

  task automatic test_wrap;
    int fd;
    rst = 1'b1; preset_en = 1'b1; preset_val = 8'd255;
    repeat (2) tick();
    rst = 1'b0; preset_en = 1'b0;
    run = 1'b1;
    wait_frame_done(100, fd);
    checks++; if (frame_cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt255: got %0d want 255", frame_cnt); end
    wait_frame_done(100, fd);
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d want 0", frame_cnt); end
    checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL wrap_seq: got %b want 0", err_seq); end
    run = 1'b0;
    wait_idle(20);
  endtask

  task automatic test_seq_error;
    int fd;
    preset_en = 1'b1; preset_val = 8'd100;
    tick();
    preset_en = 1'b0;
    run = 1'b1;
    wait_frame_done(100, fd);
    run = 1'b0;
    checks++; if (frame_cnt !== 8'd100) begin errors++; $display("FAIL seq_cnt: got %0d want 100", frame_cnt); end
    checks++; if (err_seq !== 1'b1) begin errors++; $display("FAIL seq_detect: got %b want 1", err_seq); end
    wait_idle(20);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL seq_clear: got %b want 0", err_seq); end
  endtask

  task automatic test_pattern_error;
    int fd;
    corrupt_arm = 1'b1;
    run = 1'b1;
    wait_frame_done(100, fd);
    corrupt_arm = 1'b0;
    checks++; if (err_pat !== 1'b1) begin errors++; $display("FAIL pat_detect: got %b want 1", err_pat); end
    checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL pat_seq: got %b want 0", err_seq); end
    wait_frame_done(100, fd);
    run = 1'b0;
    checks++; if (frame_cnt !== 8'd102) begin errors++; $display("FAIL pat_cnt: got %0d want 102", frame_cnt); end
    wait_idle(20);
    checks++; if (err_pat !== 1'b1) begin errors++; $display("FAIL pat_sticky: got %b want 1", err_pat); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (err_pat !== 1'b0) begin errors++; $display("FAIL pat_clear: got %b want 0", err_pat); end
  endtask

  task automatic test_backpressure;
    int fd;
    bit ok;
    run = 1'b1; out_ready = 1'b1;
    wait_word(5'd9, 100);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (out_data !== 8'd90) begin errors++; $display("FAIL bp_data: got %0d want 90", out_data); end
      checks++; if (addr_o !== 5'd9) begin errors++; $display("FAIL bp_addr: got %0d want 9", addr_o); end
      checks++; if (out_valid !== 1'b1 || out_idx !== 5'd9) begin errors++; $display("FAIL bp_hold: got v%b idx %0d want v1 idx 9", out_valid, out_idx); end
    end
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid && out_idx != 5'd9) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || out_idx !== 5'd10 || out_data !== 8'd100) begin
      errors++;
      $display("FAIL bp_next: got found%b idx %0d data %0d want idx 10 data 100", ok, out_idx, out_data);
    end
    run = 1'b0;
    wait_frame_done(100, fd);
    wait_idle(20);
    checks++; if (err_pat !== 1'b0) begin errors++; $display("FAIL bp_pat: got %b want 0", err_pat); end
  endtask

  task automatic test_reset_midframe;
    int fd;
    run = 1'b1;
    wait_word(5'd12, 100);
    rst = 1'b1;
    tick();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_fd: got %b want 0", frame_done); end
    checks++; if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_data !== 8'd0) begin
      errors++; $display("FAIL mid_out: got v%b idx %0d data %0d want v0 idx 0 data 0", out_valid, out_idx, out_data); end
    checks++; if (addr_o !== 5'd31 || busy !== 1'b0) begin errors++; $display("FAIL mid_ctl: got addr %0d busy %b want 31 0", addr_o, busy); end
    checks++; if (frame_cnt !== 8'd0 || err_pat !== 1'b0 || err_seq !== 1'b0) begin
      errors++; $display("FAIL mid_status: got cnt %0d err %b%b want 0 00", frame_cnt, err_pat, err_seq); end
    rst = 1'b0;
    wait_word(5'd0, 20);
    checks++; if (out_idx !== 5'd0) begin errors++; $display("FAIL mid_restart: got idx %0d want 0", out_idx); end
    run = 1'b0;
    wait_frame_done(100, fd);
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_wrap();
    test_seq_error();
    test_pattern_error();
    test_backpressure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
